// File: rtl/exc_sched_pkg.sv
// exc_sched_pkg: exception codes, flag/status bit indices and scheduler state shared by exc_sched and its encoder
package exc_sched_pkg;

    localparam logic [4:0] EXC_NONE = 5'h00;
    localparam logic [4:0] EXC_INT  = 5'h01;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    localparam int F_ADEL    = 0;
    localparam int F_TLBMISS = 1;
    localparam int F_RI      = 2;
    localparam int F_OV      = 3;
    localparam int F_SYS     = 4;
    localparam int F_BP      = 5;
    localparam int F_ADES    = 6;
    localparam int F_ERET    = 7;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;

    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

    typedef struct packed {
        logic [4:0]  code;
        logic        tlb;
        logic        load;
        logic        exl;
        logic        ds;
        logic [31:0] pc;
        logic [31:0] bad;
    } exc_rec_t;

endpackage

// File: rtl/exc_sched_prio_enc.sv
// exc_prio_enc: fixed-priority pick of one exception cause; tlbmiss has no code and is flagged separately
module exc_prio_enc
    import exc_sched_pkg::*;
(
    input  logic [7:0] i_flags,
    input  logic       i_int,
    output logic [4:0] o_code,
    output logic       o_tlbmiss,
    output logic       o_any
);

    always_comb begin
        o_code    = i_int              ? EXC_INT  :
                    i_flags[F_ADEL]    ? EXC_ADEL :
                    i_flags[F_TLBMISS] ? EXC_NONE :
                    i_flags[F_RI]      ? EXC_RI   :
                    i_flags[F_OV]      ? EXC_OV   :
                    i_flags[F_SYS]     ? EXC_SYS  :
                    i_flags[F_BP]      ? EXC_BP   :
                    i_flags[F_ADES]    ? EXC_ADES :
                    i_flags[F_ERET]    ? EXC_ERET : EXC_NONE;
        o_tlbmiss = ~i_int & ~i_flags[F_ADEL] & i_flags[F_TLBMISS];
        o_any     = i_int | (|i_flags);
    end

endmodule

// File: rtl/exc_sched.sv
// exc_sched: MEM-stage exception/interrupt scheduler -> drain -> one CP0 command -> flush+redirect.
// Optional EXC_SCHED_STATS_EN adds exc_count_o and sticky timeout_o.
module exc_sched
    import exc_sched_pkg::*;
#(
    parameter int          DRAIN_TIMEOUT = 15,
    parameter logic [31:0] VEC_GENERAL   = 32'h180,
    parameter logic [31:0] VEC_REFILL    = 32'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid_i,
    input  logic [7:0]  exc_flags_i,
    input  logic        exc_load_i,
    input  logic [31:0] exc_pc_i,
    input  logic        exc_ds_i,
    input  logic [31:0] exc_badvaddr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] ebase_i,
    input  logic        mem_busy_i,
`ifdef EXC_SCHED_STATS_EN
    output logic [15:0] exc_count_o,
    output logic [0:0]  timeout_o,
`endif
    output logic [31:0] exceptionType_o,
    output logic        tlbmiss_o,
    output logic        load_o,
    output logic [31:0] exceptionAddr_o,
    output logic        in_delay_slot_o,
    output logic [31:0] badVaddr_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        new_pc_valid_o
);

    localparam int CW = $clog2(DRAIN_TIMEOUT + 2);

    state_t         r_state, w_next;
    exc_rec_t       r_rec;
    logic [CW-1:0]  r_cnt;
    logic [4:0]     w_code;
    logic           w_tlb, w_any, w_int_p, w_take, w_drain, w_commit, w_redir, w_to, w_exit;
    logic           w_unused;

    assign w_unused = &{1'b0, status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};
    assign w_int_p  = (|(cause_i[15:8] & status_i[15:8])) & status_i[ST_IE] & ~status_i[ST_EXL];

    exc_prio_enc u_enc (
        .i_flags   (exc_flags_i),
        .i_int     (w_int_p),
        .o_code    (w_code),
        .o_tlbmiss (w_tlb),
        .o_any     (w_any)
    );

    // Counter is primed to 1 on take so DRAIN lasts at most DRAIN_TIMEOUT cycles
    always_comb begin
        w_drain  = r_state == DRAIN;
        w_commit = r_state == COMMIT;
        w_redir  = r_state == REDIRECT;
        w_take   = (r_state == IDLE) & exc_valid_i & w_any;
        w_to     = r_cnt == CW'(DRAIN_TIMEOUT);
        w_exit   = ~mem_busy_i | w_to;
        w_next   = r_state == IDLE   ? (w_take ? DRAIN : IDLE) :
                   w_drain           ? (w_exit ? COMMIT : DRAIN) :
                   w_commit          ? REDIRECT : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rec   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_take | (w_drain & ~w_exit)) ? r_cnt + CW'(1) : '0;
            if (w_take)
                r_rec <= '{code: w_code, tlb: w_tlb, load: exc_load_i, exl: status_i[ST_EXL],
                           ds: exc_ds_i, pc: exc_pc_i, bad: exc_badvaddr_i};
        end
    end

    always_comb begin
        exceptionType_o = w_commit ? {27'b0, r_rec.code} : '0;
        tlbmiss_o       = w_commit & r_rec.tlb;
        load_o          = w_commit & r_rec.tlb & r_rec.load;
        exceptionAddr_o = w_commit ? r_rec.pc : '0;
        in_delay_slot_o = w_commit & r_rec.ds;
        badVaddr_o      = w_commit ? r_rec.bad : '0;
        stall_o         = w_take | w_drain | w_commit;
        flush_o         = w_redir;
        new_pc_valid_o  = w_redir;
        new_pc_o        = !w_redir                    ? '0 :
                          r_rec.code == EXC_ERET      ? epc_i :
                          (r_rec.tlb & ~r_rec.exl)    ? ebase_i + VEC_REFILL :
                                                        ebase_i + VEC_GENERAL;
    end

`ifdef EXC_SCHED_STATS_EN
    logic [15:0] r_count;
    logic        r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_count   <= r_count + {15'b0, w_commit & ~&r_count};
            r_timeout <= r_timeout | (w_drain & mem_busy_i & w_to);
        end
    end

    assign exc_count_o  = r_count;
    assign timeout_o[0] = r_timeout;
`endif

endmodule
